// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stage bit positions,
// stop levels, exception type codes, state encodings and small helpers.
package pipe_ctrl_pkg;

    // Bit positions inside the 6-bit stall vector
    localparam int STG_PC  = 0;
    localparam int STG_IF  = 1;
    localparam int STG_ID  = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;
    localparam int STG_WB  = 5;

    // Stall levels
    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Exception type codes delivered by MEM
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_BREAK   = 32'h0000_0009;
    localparam logic [31:0] EXC_RI      = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    // Controller states
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_PEND     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    // Stall vector with every stage up to and including 'top_stage' stopped.
    function automatic logic [5:0] stall_upto(input int top_stage);
        logic [5:0] v;
        v = {6{NO_STOP}};
        for (int s = STG_PC; s <= STG_WB; s++) begin
            if (s <= top_stage) v[s] = STOP;
        end
        return v;
    endfunction

    // Redirect target for a nonzero exception type: ERET returns to EPC,
    // every other code (listed or not) goes to the common vector.
    function automatic logic [31:0] redirect_target(input logic [31:0] t,
                                                    input logic [31:0] epc,
                                                    input logic [31:0] vec);
        logic [31:0] r;
        case (t)
            EXC_ERET: r = epc;
            EXC_INT, EXC_SYSCALL, EXC_BREAK,
            EXC_RI, EXC_OV, EXC_TRAP: r = vec;
            default:  r = vec;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles where inc_i is high, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: hold once all-ones so the count never wraps
    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: stall arbitration across ID/EX/MEM, exception
// redirect sequencing (including exceptions held behind a MEM bus stall),
// and saturating debug counters for stall cycles and flushes.
//
// Handshake: there is no valid/ready pairing here; stall and flush are
// level outputs sampled by every stage register on the rising clock edge,
// and new_pc is meaningful only in a cycle where flush=1.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_from_id,
    input  logic             stallreq_from_ex,
    input  logic             stallreq_from_mem,
    input  logic [31:0]      excepttype_i,
    input  logic [31:0]      cp0_epc_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [31:0]      stall_cycles_o,
    output logic [CNT_W-1:0] exc_count_o,
    output logic [1:0]       state_o
);

    localparam logic [5:0] STALL_MEM  = stall_upto(STG_MEM);
    localparam logic [5:0] STALL_EX   = stall_upto(STG_EX);
    localparam logic [5:0] STALL_ID   = stall_upto(STG_ID);
    localparam logic [5:0] STALL_NONE = {6{NO_STOP}};

    state_e      state_q, state_d;
    logic [31:0] exc_q, exc_d;

    logic [5:0]  stall_c;
    logic        flush_c;
    logic [31:0] new_pc_c;
    logic [5:0]  req_stall;
    logic        exc_present;

    assign exc_present = (excepttype_i != ZERO_WORD);

    // Priority stall encoding: the deepest requesting stage wins
    always_comb begin
        req_stall = STALL_NONE;
        if (stallreq_from_mem)     req_stall = STALL_MEM;
        else if (stallreq_from_ex) req_stall = STALL_EX;
        else if (stallreq_from_id) req_stall = STALL_ID;
    end

    // Next state, exception latch and redirect outputs
    always_comb begin
        state_d  = state_q;
        exc_d    = exc_q;
        stall_c  = STALL_NONE;
        flush_c  = 1'b0;
        new_pc_c = ZERO_WORD;
        case (state_q)
            ST_RUN: begin
                if (!exc_present) begin
                    stall_c = req_stall;
                end else if (!stallreq_from_mem) begin
                    // Exception taken immediately, overriding ID/EX holds
                    flush_c  = 1'b1;
                    new_pc_c = redirect_target(excepttype_i, cp0_epc_i, EXC_VECTOR);
                    state_d  = ST_REDIRECT;
                end else begin
                    // MEM bus busy: park the exception until it frees up
                    stall_c = STALL_MEM;
                    exc_d   = excepttype_i;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (stallreq_from_mem) begin
                    stall_c = STALL_MEM;
                end else begin
                    flush_c  = 1'b1;
                    new_pc_c = redirect_target(exc_q, cp0_epc_i, EXC_VECTOR);
                    exc_d    = ZERO_WORD;
                    state_d  = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // One bubble-only cycle; all requests are ignored
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (rst) begin
            stall_c  = STALL_NONE;
            flush_c  = 1'b0;
            new_pc_c = ZERO_WORD;
        end
    end

    // State and latched exception type
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            exc_q   <= ZERO_WORD;
        end else begin
            state_q <= state_d;
            exc_q   <= exc_d;
        end
    end

    assign stall   = stall_c;
    assign flush   = flush_c;
    assign new_pc  = new_pc_c;
    assign state_o = state_q;

    sat_counter #(.W(32)) u_stall_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (stall_c[STG_PC]),
        .count_o (stall_cycles_o)
    );

    sat_counter #(.W(CNT_W)) u_exc_cnt (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (flush_c),
        .count_o (exc_count_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl, built with a 4-bit flush counter so that
// saturation of exc_count_o is reachable in a short run.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        id_req, ex_req, mem_req;
  logic [31:0] exc_type, epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic [31:0] stall_cycles;
  logic [3:0]  exc_count;
  logic [1:0]  state;

  int errors = 0;
  int checks = 0;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0020), .CNT_W(4)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_from_id  (id_req),
    .stallreq_from_ex  (ex_req),
    .stallreq_from_mem (mem_req),
    .excepttype_i      (exc_type),
    .cp0_epc_i         (epc),
    .stall             (stall),
    .flush             (flush),
    .new_pc            (new_pc),
    .stall_cycles_o    (stall_cycles),
    .exc_count_o       (exc_count),
    .state_o           (state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; id_req = 0; ex_req = 0; mem_req = 1; exc_type = 0; epc = 0;
    #2;
    chk("rst_stall_forced", {26'd0, stall}, 32'h0);
    chk("rst_flush", {31'd0, flush}, 32'h0);
    chk("rst_stall_cycles", stall_cycles, 32'h0);
    chk("rst_exc_count", {28'd0, exc_count}, 32'h0);
    chk("rst_state", {30'd0, state}, {30'd0, ST_RUN});

    // Release reset, idle 10 cycles
    @(negedge clk); mem_req = 0; rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_stall", {26'd0, stall}, 32'h0);
      chk("idle_flush", {31'd0, flush}, 32'h0);
      @(negedge clk);
    end
    chk("idle_stall_cycles", stall_cycles, 32'd0);

    // ID + EX requests for 3 cycles: EX wins
    id_req = 1; ex_req = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("id_ex_stall", {26'd0, stall}, 32'h0000_000f);
      @(negedge clk);
    end
    id_req = 0; ex_req = 0; #1;
    chk("after_id_ex_stall", {26'd0, stall}, 32'h0);
    chk("id_ex_stall_cycles", stall_cycles, 32'd3);

    // ID alone, then MEM alone
    @(negedge clk); id_req = 1; #1;
    chk("id_only_stall", {26'd0, stall}, 32'h0000_0007);
    @(negedge clk); id_req = 0; mem_req = 1; ex_req = 1; #1;
    chk("mem_ex_stall", {26'd0, stall}, 32'h0000_001f);
    @(negedge clk); mem_req = 0; ex_req = 0; #1;
    chk("stall_cycles_5", stall_cycles, 32'd5);

    // SYSCALL in RUN with an ID hold pending: immediate flush
    @(negedge clk); exc_type = EXC_SYSCALL; id_req = 1; #1;
    chk("sys_flush", {31'd0, flush}, 32'h1);
    chk("sys_new_pc", new_pc, 32'h0000_0020);
    chk("sys_stall", {26'd0, stall}, 32'h0);
    @(negedge clk); #1;  // REDIRECT, inputs still asserted
    chk("redir_flush", {31'd0, flush}, 32'h0);
    chk("redir_stall", {26'd0, stall}, 32'h0);
    chk("redir_state", {30'd0, state}, {30'd0, ST_REDIRECT});
    chk("sys_exc_count", {28'd0, exc_count}, 32'd1);
    @(negedge clk); exc_type = 0; id_req = 0; #1;
    chk("back_run", {30'd0, state}, {30'd0, ST_RUN});
    chk("sys_stall_cycles", stall_cycles, 32'd5);

    // ERET behind a MEM stall for 4 cycles
    @(negedge clk); exc_type = EXC_ERET; epc = 32'hBFC0_0100; mem_req = 1; #1;
    chk("pend0_stall", {26'd0, stall}, 32'h0000_001f);
    chk("pend0_flush", {31'd0, flush}, 32'h0);
    @(negedge clk); exc_type = 0; #1;
    chk("pend1_stall", {26'd0, stall}, 32'h0000_001f);
    chk("pend1_state", {30'd0, state}, {30'd0, ST_PEND});
    @(negedge clk); exc_type = EXC_SYSCALL; id_req = 1; #1;  // ignored in PEND
    chk("pend2_stall", {26'd0, stall}, 32'h0000_001f);
    chk("pend2_flush", {31'd0, flush}, 32'h0);
    @(negedge clk); #1;
    chk("pend3_stall", {26'd0, stall}, 32'h0000_001f);
    @(negedge clk); mem_req = 0; #1;
    chk("pend_flush", {31'd0, flush}, 32'h1);
    chk("pend_new_pc", new_pc, 32'hBFC0_0100);
    chk("pend_flush_stall", {26'd0, stall}, 32'h0);
    @(negedge clk); #1;
    chk("pend_redir_flush", {31'd0, flush}, 32'h0);
    chk("pend_redir_stall", {26'd0, stall}, 32'h0);
    chk("eret_exc_count", {28'd0, exc_count}, 32'd2);
    chk("eret_stall_cycles", stall_cycles, 32'd9);
    @(negedge clk); exc_type = 0; id_req = 0;

    // Reset in the middle of PEND
    @(negedge clk); exc_type = EXC_OV; mem_req = 1; #1;
    chk("ov_pend_stall", {26'd0, stall}, 32'h0000_001f);
    @(negedge clk); exc_type = 0; rst = 1; #1;
    chk("rst_pend_stall", {26'd0, stall}, 32'h0);
    chk("rst_pend_flush", {31'd0, flush}, 32'h0);
    chk("rst_pend_state", {30'd0, state}, {30'd0, ST_RUN});
    chk("rst_pend_exc_count", {28'd0, exc_count}, 32'd0);
    chk("rst_pend_stall_cycles", stall_cycles, 32'd0);
    @(negedge clk); rst = 0; mem_req = 0; #1;
    chk("post_rst_flush", {31'd0, flush}, 32'h0);
    @(negedge clk); #1;
    chk("post_rst_flush2", {31'd0, flush}, 32'h0);
    chk("post_rst_state", {30'd0, state}, {30'd0, ST_RUN});
    chk("post_rst_exc_count", {28'd0, exc_count}, 32'd0);

    // Direct ERET and an unlisted code
    @(negedge clk); exc_type = EXC_ERET; epc = 32'h0000_1234; #1;
    chk("eret_direct_pc", new_pc, 32'h0000_1234);
    @(negedge clk); exc_type = 0;
    @(negedge clk); exc_type = 32'h0000_0040; #1;
    chk("other_code_pc", new_pc, 32'h0000_0020);
    @(negedge clk); exc_type = 0; #1;
    chk("exc_count_2", {28'd0, exc_count}, 32'd2);

    // 15 more interrupts: the 4-bit counter must stop at 15
    for (int i = 0; i < 15; i++) begin
      @(negedge clk); exc_type = EXC_INT; #1;
      if (i == 0) chk("int_pc", new_pc, 32'h0000_0020);
      @(negedge clk); #1;
      if (i == 0) chk("int_no_double_flush", {31'd0, flush}, 32'h0);
      exc_type = 0;
    end
    @(negedge clk); #1;
    chk("exc_count_sat", {28'd0, exc_count}, 32'h0000_000f);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
